// File: rtl/fifo_serializer_pkg.sv
// rtl/fifo_serializer_pkg.sv - state encoding and line levels for fifo_serializer (optional FIFO_SERIALIZER_PARITY_EN)
package fifo_serializer_pkg;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // PARITY only exists when the parity bit is built in
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
`ifdef FIFO_SERIALIZER_PARITY_EN
    PARITY = 3'd5,
`endif
    STOP   = 3'd4
  } ser_state_e;

endpackage

// File: rtl/fifo_serializer_bit_timer.sv
// rtl/fifo_serializer_bit_timer.sv - BIT_CYCLES counter pacing each serial bit
module bit_timer #(
  parameter int BIT_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic tick_o,
  output logic pre_tick_o
);

  localparam int TW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

  logic [TW-1:0] cnt;

  // tick marks the last cycle of a bit period
  assign tick_o = (cnt == TW'(BIT_CYCLES - 1));

  // pre_tick marks the cycle before the last one; with one cycle per bit every cycle qualifies
  if (BIT_CYCLES == 1) begin : g_single
    assign pre_tick_o = 1'b1;
  end else begin : g_multi
    assign pre_tick_o = (cnt == TW'(BIT_CYCLES - 2));
  end

  // free-running bit-period counter, wraps to 0 on every bit boundary
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else if (clr_i || tick_o) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_serializer.sv
// rtl/fifo_serializer.sv - FIFO-fed LSB-first serializer with start/stop framing (optional FIFO_SERIALIZER_PARITY_EN)
module fifo_serializer
  import fifo_serializer_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int BIT_CYCLES = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             pnding_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             pop_o,
  output logic             ser_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int IW = $clog2(WIDTH + 1);

  ser_state_e       state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_nxt;
  logic [IW-1:0]    bit_idx;
  logic             tick;
  logic             pre_tick;
  logic             tmr_clr;
`ifdef FIFO_SERIALIZER_PARITY_EN
  logic             par_q;
`endif

  // timer is held at zero until the frame's first line bit begins
  assign tmr_clr   = (state == IDLE) || (state == LOAD);
  assign shreg_nxt = shreg >> 1;

  bit_timer #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_bit_timer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (tmr_clr),
    .tick_o    (tick),
    .pre_tick_o(pre_tick)
  );

  // frame sequencer; every output is registered and set for the state being entered
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      ser_o   <= STOP_BIT;
      pop_o   <= 1'b0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      shreg   <= '0;
      bit_idx <= '0;
`ifdef FIFO_SERIALIZER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      pop_o  <= 1'b0;
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          ser_o  <= STOP_BIT;
          busy_o <= 1'b0;
          if (pnding_i && en_i) begin
            state  <= LOAD;
            pop_o  <= 1'b1;
            busy_o <= 1'b1;
          end
        end
        LOAD: begin
          shreg   <= data_i;
          bit_idx <= '0;
`ifdef FIFO_SERIALIZER_PARITY_EN
          par_q   <= ^data_i;
`endif
          ser_o   <= START_BIT;
          state   <= START;
        end
        START: begin
          if (tick) begin
            ser_o <= shreg[0];
            state <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            shreg   <= shreg_nxt;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == IW'(WIDTH - 1)) begin
`ifdef FIFO_SERIALIZER_PARITY_EN
              ser_o <= par_q;
              state <= PARITY;
`else
              ser_o  <= STOP_BIT;
              done_o <= (BIT_CYCLES == 1);
              state  <= STOP;
`endif
            end else begin
              ser_o <= shreg_nxt[0];
            end
          end
        end
`ifdef FIFO_SERIALIZER_PARITY_EN
        PARITY: begin
          if (tick) begin
            ser_o  <= STOP_BIT;
            done_o <= (BIT_CYCLES == 1);
            state  <= STOP;
          end
        end
`endif
        STOP: begin
          if (tick) begin
            busy_o <= 1'b0;
            state  <= IDLE;
          end else if (pre_tick) begin
            done_o <= 1'b1;
          end
        end
        default: begin
          ser_o  <= STOP_BIT;
          busy_o <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_serializer.sv
// tb/tb_fifo_serializer.sv - directed self-checking bench for fifo_serializer
module tb_fifo_serializer;

  localparam int W  = 8;
  localparam int BC = 4;
`ifdef FIFO_SERIALIZER_PARITY_EN
  localparam int FL = 45;
  localparam int NB = 11;
`else
  localparam int FL = 41;
  localparam int NB = 10;
`endif
  localparam int PERIOD = FL + 1;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         en_i;
  logic         pnding_i;
  logic [W-1:0] data_i;
  logic         pop_o;
  logic         ser_o;
  logic         busy_o;
  logic         done_o;

  int checks = 0;
  int errors = 0;

  fifo_serializer #(
    .WIDTH     (W),
    .BIT_CYCLES(BC)
  ) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (en_i),
    .pnding_i(pnding_i),
    .data_i  (data_i),
    .pop_o   (pop_o),
    .ser_o   (ser_o),
    .busy_o  (busy_o),
    .done_o  (done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // waits for the LOAD pop, then follows one whole frame cycle by cycle
  task automatic frame_check(input string tag, input logic [W-1:0] w, input logic par,
                             input bit drop_pnd, input int en_drop_at);
    logic bits [0:NB-1];
    bit   seen;
    int   ser_err, busy_err, extra_pop, done_cnt, done_pos;
    logic exp;
    seen = 1'b0;
    for (int t = 0; t < 8 && !seen; t++) begin
      @(negedge clk_i);
      seen = pop_o;
    end
    chk({tag, "_pop_seen"}, 32'(seen), 32'd1);
    if (!seen) return;
    bits[0] = 1'b0;
    for (int i = 0; i < W; i++) bits[1+i] = w[i];
`ifdef FIFO_SERIALIZER_PARITY_EN
    bits[W+1] = par;
`else
    if (par) bits[0] = 1'b0;
`endif
    bits[NB-1] = 1'b1;
    ser_err = 0; busy_err = 0; extra_pop = 0; done_cnt = 0; done_pos = -1;
    for (int k = 0; k < FL; k++) begin
      if (k > 0) @(negedge clk_i);
      if (k == 0 && drop_pnd) pnding_i = 1'b0;
      if (k == en_drop_at) en_i = 1'b0;
      exp = (k == 0) ? 1'b1 : bits[(k-1)/BC];
      if (ser_o !== exp) ser_err++;
      if (k > 0 && pop_o) extra_pop++;
      if (busy_o !== 1'b1) busy_err++;
      if (done_o) begin
        done_cnt++;
        done_pos = k;
      end
    end
    chk({tag, "_ser_errs"}, 32'(ser_err), 32'd0);
    chk({tag, "_busy_errs"}, 32'(busy_err), 32'd0);
    chk({tag, "_extra_pop"}, 32'(extra_pop), 32'd0);
    chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    chk({tag, "_done_pos"}, 32'(done_pos), 32'(FL - 1));
    @(negedge clk_i);
    chk({tag, "_end_busy"}, 32'(busy_o), 32'd0);
    chk({tag, "_end_ser"}, 32'(ser_o), 32'd1);
  endtask

  logic [W-1:0] q[$];
  logic         ser_log [0:199];
  int           pop_t [0:2];

  initial begin
    int np, nd, viol, pops, t;
    bit pend_pop, seen;
    logic [W-1:0] word;

    rst_i = 1'b1; en_i = 1'b0; pnding_i = 1'b0; data_i = '0;
    repeat (2) @(negedge clk_i);
    chk("rst_ser", 32'(ser_o), 32'd1);
    chk("rst_pop", 32'(pop_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    rst_i = 1'b0;

    // idle line with nothing pending
    en_i = 1'b1;
    viol = 0;
    repeat (50) begin
      @(negedge clk_i);
      if (ser_o !== 1'b1 || pop_o !== 1'b0 || busy_o !== 1'b0) viol++;
    end
    chk("idle_viol", 32'(viol), 32'd0);

    // single frame 8'hA5: line 0,1,0,1,0,0,1,0,1,(parity 0),1
    data_i = 8'hA5; pnding_i = 1'b1;
    frame_check("a5", 8'hA5, 1'b0, 1'b1, -1);

`ifdef FIFO_SERIALIZER_PARITY_EN
    // 8'h07 has three ones, so the parity bit is 1
    data_i = 8'h07; pnding_i = 1'b1;
    frame_check("par07", 8'h07, 1'b1, 1'b1, -1);
`endif

    // three queued words, pnding held while the queue is non-empty
    q = '{8'h3C, 8'h81, 8'hFF};
    data_i = q[0]; pnding_i = 1'b1; en_i = 1'b1;
    np = 0; nd = 0; pops = 0; pend_pop = 1'b0;
    for (int c = 0; c < 3*PERIOD + 20; c++) begin
      @(negedge clk_i);
      if (pend_pop) begin
        void'(q.pop_front());
        data_i   = (q.size() > 0) ? q[0] : '0;
        pnding_i = (q.size() > 0);
      end
      pend_pop = pop_o;
      if (pop_o) begin
        if (np < 3) pop_t[np] = c;
        np++;
      end
      if (done_o) nd++;
      if (c < 200) ser_log[c] = ser_o;
    end
    chk("b2b_pops", 32'(np), 32'd3);
    chk("b2b_dones", 32'(nd), 32'd3);
    if (np >= 3) begin
      chk("b2b_gap1", 32'(pop_t[1] - pop_t[0]), 32'(PERIOD));
      chk("b2b_gap2", 32'(pop_t[2] - pop_t[1]), 32'(PERIOD));
      for (int f = 0; f < 3; f++) begin
        for (int i = 0; i < W; i++) word[i] = ser_log[pop_t[f] + 1 + BC*(1+i) + BC/2];
        case (f)
          0: chk("b2b_word0", 32'(word), 32'h3C);
          1: chk("b2b_word1", 32'(word), 32'h81);
          default: chk("b2b_word2", 32'(word), 32'hFF);
        endcase
      end
    end

    // reset in the middle of a frame
    data_i = 8'h5A; pnding_i = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk_i);
      seen = pop_o;
    end
    chk("mid_rst_pop_seen", 32'(seen), 32'd1);
    pnding_i = 1'b0;
    repeat (15) @(negedge clk_i);
    chk("mid_rst_busy_before", 32'(busy_o), 32'd1);
    rst_i = 1'b1;
    #1;
    chk("mid_rst_ser", 32'(ser_o), 32'd1);
    chk("mid_rst_busy", 32'(busy_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    viol = 0;
    repeat (50) begin
      @(negedge clk_i);
      if (done_o !== 1'b0 || pop_o !== 1'b0 || busy_o !== 1'b0 || ser_o !== 1'b1) viol++;
    end
    chk("mid_rst_quiet", 32'(viol), 32'd0);
    data_i = 8'hC3; pnding_i = 1'b1;
    frame_check("post_rst", 8'hC3, 1'b0, 1'b1, -1);

    // en dropped mid-frame: frame completes, no reload until en returns
    data_i = 8'h3C; pnding_i = 1'b1; en_i = 1'b1;
    frame_check("en_drop", 8'h3C, 1'b0, 1'b0, 10);
    pops = 0;
    repeat (10) begin
      @(negedge clk_i);
      if (pop_o) pops++;
    end
    chk("en_drop_no_load", 32'(pops), 32'd0);
    en_i = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      @(negedge clk_i);
      seen = pop_o;
    end
    chk("en_back_load", 32'(seen), 32'd1);
    pnding_i = 1'b0;
    t = 0;
    while (busy_o && t < 2*PERIOD) begin
      @(negedge clk_i);
      t++;
    end
    chk("en_back_finish", 32'(busy_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
